addr_walker: RTL
================

# addr_walker

Address walker that consumes a 14-bit base address produced by the control address lookup and expands it into a burst of memory word addresses. It is the read side of the address path: control selects a base, and this block streams successive addresses to the matrix/sample memory port under a valid/ready handshake. Bits [13:12] select the bank and stay fixed for the whole burst. Bits [11:0] are the word offset and step through the burst.

## Interface
Parameters:
- ADDR_W, 14, total address width; bank field is [ADDR_W-1:ADDR_W-2], offset field is the rest
- LEN_W, 12, burst length counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  burst request, sampled only in IDLE
- base_addr  in  ADDR_W  first address of burst, captured on accepted start
- len  in  LEN_W  number of words in burst, captured on accepted start; 0 is legal
- stride  in  4  offset increment, captured on accepted start; port exists only with ADDR_WALK_STRIDE_EN
- busy  out  1  high in RUN and DONE
- mem_addr  out  ADDR_W  current address
- mem_valid  out  1  mem_addr is valid
- mem_ready  in  1  consumer accepts the current address
- last  out  1  qualifies the final beat, high only together with mem_valid
- done  out  1  one-cycle pulse after the burst completes

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and len≠0: capture base_addr, len and stride, then go to RUN.
  - If start=1 and len=0: go directly to DONE; no beat is issued.
- RUN:
  - mem_valid=1.
  - On a handshake (mem_valid & mem_ready), the offset advances by the step; the bank bits are unchanged.
  - The remaining count decrements on each handshake.
  - last=1 when remaining count = 1.
  - A handshake with last=1 goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Offset arithmetic:
  - Next offset = (offset + step) mod 2^(ADDR_W-2), i.e. an unsigned wrap within the bank.
  - A carry never propagates into the bank bits.
- start outside IDLE is ignored and does not queue.
- mem_addr, mem_valid and last are registered and hold stable while mem_valid=1 and mem_ready=0.
- Reset at any cycle, including mid-burst, gives immediate IDLE. The outstanding burst is abandoned with no done pulse.

## Timing
- Reset values: mem_addr=0, mem_valid=0, last=0, done=0, busy=0.
- start accepted at edge t: mem_valid=1 and mem_addr=base_addr from t+1.
- With mem_ready held high, one address is issued per cycle.
  - A burst of N beats occupies cycles t+1..t+N.
  - done pulses at t+N+1.
  - The next start is accepted at t+N+2.
- len=0: done pulses at t+1 with no mem_valid.
- mem_ready stalls insert cycles 1:1; there are no bubbles between handshakes.
- mem_ready is ignored when mem_valid=0.

## Configuration
- ADDR_WALK_STRIDE_EN defined:
  - The stride port is present.
  - step = captured stride.
  - stride=0 is legal and repeats the same address len times.
- Undefined:
  - The stride port is absent.
  - step is the constant 1.

## Test plan
- Linear burst: base_addr=14'h1040, len=3, mem_ready=1.
  - Required: mem_addr 1040, 1041, 1042 on consecutive cycles.
  - last only on 1042; done one cycle later; busy low after that.
- Offset wrap: base_addr=14'h0FFE, len=4.
  - Required: 0FFE, 0FFF, 0000, 0001; bank stays 00.
- Bank preserved at wrap: base_addr=14'h3FFF, len=2.
  - Required: 3FFF, then 3000, never 0000.
- Backpressure and ignored start: base_addr=14'h0004, len=2, mem_ready low for 3 cycles on the first beat, start pulsed during RUN.
  - Required: 0004 held stable 4 cycles, then 0005.
  - Second start has no effect.
  - Exactly one done.
- Zero length and reset:
  - len=0 gives a done pulse at t+1 with mem_valid never high.
  - Separately, rst asserted after the 2nd beat of a len=5 burst gives all outputs 0 next cycle and no done.
- Stride (macro defined): base_addr=14'h3060, stride=4, len=3.
  - Required: 3060, 3064, 3068.
  - With the macro undefined, the same run gives 3060, 3061, 3062.

Source files
------------

// File: rtl/addr_walker.sv
// Burst address walker: expands a banked base address into successive word addresses under valid/ready.
// Optional ADDR_WALK_STRIDE_EN adds a 4-bit stride port; otherwise the offset steps by 1.
module addr_walker #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef ADDR_WALK_STRIDE_EN
  input  logic [3:0]        stride,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              last,
  output logic              done
);
  localparam int OFF_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0] cnt_q;
  logic [3:0]       step_q;
  logic [OFF_W-1:0] step_ext, next_off;
  logic             hs, accept;

`ifdef ADDR_WALK_STRIDE_EN
  always_ff @(posedge clk) begin
    if (rst)         step_q <= '0;
    else if (accept) step_q <= stride;
  end
`else
  assign step_q = 4'd1;
`endif

  assign hs       = mem_valid & mem_ready;
  assign accept   = (state_q == IDLE) && start && (len != '0);
  assign step_ext = {{(OFF_W-4){1'b0}}, step_q};
  // Offset add is OFF_W wide, so the carry out of the offset is dropped and the bank never changes.
  assign next_off = mem_addr[OFF_W-1:0] + step_ext;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:  if (hs && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      last      <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      mem_addr  <= base_addr;
      mem_valid <= 1'b1;
      last      <= (len == LEN_W'(1));
      cnt_q     <= len;
    end else if (hs) begin
      mem_addr  <= {mem_addr[ADDR_W-1:OFF_W], next_off};
      cnt_q     <= cnt_q - LEN_W'(1);
      // Final beat drops valid; otherwise last arms when one beat will remain.
      mem_valid <= !last;
      last      <= !last && (cnt_q == LEN_W'(2));
    end
  end
endmodule
